// File: rtl/ram_bus_arbiter_if.sv
// Two-master request/response bundle plus the single-port RAM side.
// slave: arbiter view; master: requester/RAM-model view.
interface ram_bus_arbiter_if;
   logic        m0_req;
   logic        m0_we;
   logic [31:0] m0_addr;
   logic [2:0]  m0_rw_type;
   logic [31:0] m0_wdata;
   logic        m0_gnt;
   logic        m0_ack;
   logic        m1_req;
   logic        m1_we;
   logic [31:0] m1_addr;
   logic [2:0]  m1_rw_type;
   logic [31:0] m1_wdata;
   logic        m1_gnt;
   logic        m1_ack;
   logic [31:0] rdata;
   logic        err;
   logic        busy;
   logic        mem_wr_en;
   logic [31:0] mem_addr;
   logic [2:0]  mem_rw_type;
   logic [31:0] mem_dat_o;
   logic [31:0] mem_dat_i;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_rw_type, m0_wdata,
      input  m1_req, m1_we, m1_addr, m1_rw_type, m1_wdata,
      input  mem_dat_i,
      output m0_gnt, m0_ack, m1_gnt, m1_ack,
      output rdata, err, busy,
      output mem_wr_en, mem_addr, mem_rw_type, mem_dat_o
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_rw_type, m0_wdata,
      output m1_req, m1_we, m1_addr, m1_rw_type, m1_wdata,
      output mem_dat_i,
      input  m0_gnt, m0_ack, m1_gnt, m1_ack,
      input  rdata, err, busy,
      input  mem_wr_en, mem_addr, mem_rw_type, mem_dat_o
   );
endinterface

// File: rtl/ram_bus_arbiter.sv
// Two-master arbiter/sequencer for the single-port data RAM.
// Fixed priority to m0 with a starvation guard for m1; range-checked.
module ram_bus_arbiter #(
   parameter int unsigned RD_LAT       = 1,
   parameter int unsigned STARVE_LIMIT = 4,
   parameter logic [31:0] ADDR_LIMIT   = 32'h4000
) (
   input logic             clk,
   input logic             rst_n,
   ram_bus_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [7:0] WAIT_INIT = 8'(RD_LAT - 1);
   localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

   state_t      state, state_n;
   logic [7:0]  wait_cnt, wait_cnt_n;
   logic [7:0]  starve_cnt, starve_cnt_n;
   logic        id, id_n;
   logic        we_l, we_l_n;
   logic        bad_l, bad_l_n;
   logic [31:0] addr_l, addr_l_n;
   logic [2:0]  rw_l, rw_l_n;
   logic [31:0] wdata_l, wdata_l_n;

   logic        gnt0, gnt0_n, gnt1, gnt1_n;
   logic        ack0, ack0_n, ack1, ack1_n;
   logic [31:0] rdata, rdata_n;
   logic        err, err_n;
   logic        wr_en, wr_en_n;
   logic [31:0] maddr, maddr_n;
   logic [2:0]  mrw, mrw_n;
   logic [31:0] mdat, mdat_n;

   logic        pick;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic [2:0]  sel_rw;
   logic [31:0] sel_wdata;

   // Arbitration: m1 wins alone, or in a contest once starved out.
   always_comb begin
      pick = bus.m1_req &
             (~bus.m0_req | (starve_cnt == STARVE_MAX));
      sel_we    = pick ? bus.m1_we      : bus.m0_we;
      sel_addr  = pick ? bus.m1_addr    : bus.m0_addr;
      sel_rw    = pick ? bus.m1_rw_type : bus.m0_rw_type;
      sel_wdata = pick ? bus.m1_wdata   : bus.m0_wdata;
   end

   // Next state plus next value of every registered output.
   always_comb begin
      state_n      = state;
      wait_cnt_n   = wait_cnt;
      starve_cnt_n = starve_cnt;
      id_n         = id;
      we_l_n       = we_l;
      bad_l_n      = bad_l;
      addr_l_n     = addr_l;
      rw_l_n       = rw_l;
      wdata_l_n    = wdata_l;
      gnt0_n       = 1'b0;
      gnt1_n       = 1'b0;
      ack0_n       = 1'b0;
      ack1_n       = 1'b0;
      rdata_n      = 32'h0;
      err_n        = 1'b0;
      wr_en_n      = 1'b0;
      maddr_n      = 32'h0;
      mrw_n        = 3'b000;
      mdat_n       = 32'h0;
      unique case (state)
         IDLE: begin
            if (bus.m0_req | bus.m1_req) begin
               if (~bus.m1_req | pick)
                  starve_cnt_n = 8'h0;
               else if (starve_cnt != STARVE_MAX)
                  starve_cnt_n = starve_cnt + 8'h1;
               id_n      = pick;
               we_l_n    = sel_we;
               addr_l_n  = sel_addr;
               rw_l_n    = sel_rw;
               wdata_l_n = sel_wdata;
               bad_l_n   = (sel_addr >= ADDR_LIMIT);
               gnt0_n    = ~pick;
               gnt1_n    = pick;
               maddr_n   = sel_addr;
               mrw_n     = sel_rw;
               mdat_n    = sel_wdata;
               wr_en_n   = sel_we & (sel_addr < ADDR_LIMIT);
               state_n   = ISSUE;
            end
         end
         ISSUE: begin
            if (bad_l | we_l) begin
               ack0_n  = ~id;
               ack1_n  = id;
               err_n   = bad_l;
               state_n = RESP;
            end else begin
               wait_cnt_n = WAIT_INIT;
               maddr_n    = addr_l;
               mrw_n      = rw_l;
               state_n    = WAIT;
            end
         end
         WAIT: begin
            if (wait_cnt == 8'h0) begin
               rdata_n = bus.mem_dat_i;
               ack0_n  = ~id;
               ack1_n  = id;
               state_n = RESP;
            end else begin
               wait_cnt_n = wait_cnt - 8'h1;
               maddr_n    = addr_l;
               mrw_n      = rw_l;
            end
         end
         RESP: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State, latched request fields and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         wait_cnt   <= 8'h0;
         starve_cnt <= 8'h0;
         id         <= 1'b0;
         we_l       <= 1'b0;
         bad_l      <= 1'b0;
         addr_l     <= 32'h0;
         rw_l       <= 3'b000;
         wdata_l    <= 32'h0;
         gnt0       <= 1'b0;
         gnt1       <= 1'b0;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         rdata      <= 32'h0;
         err        <= 1'b0;
         wr_en      <= 1'b0;
         maddr      <= 32'h0;
         mrw        <= 3'b000;
         mdat       <= 32'h0;
      end else begin
         state      <= state_n;
         wait_cnt   <= wait_cnt_n;
         starve_cnt <= starve_cnt_n;
         id         <= id_n;
         we_l       <= we_l_n;
         bad_l      <= bad_l_n;
         addr_l     <= addr_l_n;
         rw_l       <= rw_l_n;
         wdata_l    <= wdata_l_n;
         gnt0       <= gnt0_n;
         gnt1       <= gnt1_n;
         ack0       <= ack0_n;
         ack1       <= ack1_n;
         rdata      <= rdata_n;
         err        <= err_n;
         wr_en      <= wr_en_n;
         maddr      <= maddr_n;
         mrw        <= mrw_n;
         mdat       <= mdat_n;
      end
   end

   assign bus.m0_gnt      = gnt0;
   assign bus.m1_gnt      = gnt1;
   assign bus.m0_ack      = ack0;
   assign bus.m1_ack      = ack1;
   assign bus.rdata       = rdata;
   assign bus.err         = err;
   assign bus.busy        = (state != IDLE);
   assign bus.mem_wr_en   = wr_en;
   assign bus.mem_addr    = maddr;
   assign bus.mem_rw_type = mrw;
   assign bus.mem_dat_o   = mdat;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Directed bench for ram_bus_arbiter: RD_LAT=1 and RD_LAT=3 instances,
// each with a small word RAM model of matching read latency.
module tb_ram_bus_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ram_init = 1'b1;
   int   checks = 0;
   int   failures = 0;

   ram_bus_arbiter_if bus ();
   ram_bus_arbiter_if bus3 ();

   ram_bus_arbiter #(.RD_LAT(1), .STARVE_LIMIT(4),
                     .ADDR_LIMIT(32'h4000)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));

   ram_bus_arbiter #(.RD_LAT(3), .STARVE_LIMIT(4),
                     .ADDR_LIMIT(32'h4000)) dut3 (
      .clk(clk), .rst_n(rst_n), .bus(bus3));

   always #5 clk = ~clk;

   logic [31:0] ram  [64];
   logic [31:0] ram3 [64];
   logic [31:0] d1, d2;

   // One-cycle read RAM for the RD_LAT=1 instance.
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 64; i++)
            ram[i] <= 32'hA000_0000 + 32'(i);
         bus.mem_dat_i <= 32'h0;
      end else begin
         if (bus.mem_wr_en)
            ram[bus.mem_addr[7:2]] <= bus.mem_dat_o;
         bus.mem_dat_i <= ram[bus.mem_addr[7:2]];
      end
   end

   // Three-cycle read RAM for the RD_LAT=3 instance.
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 64; i++)
            ram3[i] <= 32'hB000_0000 + 32'(i);
         d1 <= 32'h0;
         d2 <= 32'h0;
         bus3.mem_dat_i <= 32'h0;
      end else begin
         if (bus3.mem_wr_en)
            ram3[bus3.mem_addr[7:2]] <= bus3.mem_dat_o;
         d1 <= ram3[bus3.mem_addr[7:2]];
         d2 <= d1;
         bus3.mem_dat_i <= d2;
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      int g;
      bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = 0;
      bus.m0_rw_type = 0; bus.m0_wdata = 0;
      bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = 0;
      bus.m1_rw_type = 0; bus.m1_wdata = 0;
      bus3.m0_req = 0; bus3.m0_we = 0; bus3.m0_addr = 0;
      bus3.m0_rw_type = 0; bus3.m0_wdata = 0;
      bus3.m1_req = 0; bus3.m1_we = 0; bus3.m1_addr = 0;
      bus3.m1_rw_type = 0; bus3.m1_wdata = 0;

      // Reset state
      step; step;
      ram_init = 0;
      chk("rst_busy", bus.busy, 0);
      chk("rst_gnt0", bus.m0_gnt, 0);
      chk("rst_ack0", bus.m0_ack, 0);
      chk("rst_wr_en", bus.mem_wr_en, 0);
      chk("rst_addr", bus.mem_addr, 0);
      chk("rst_rdata", bus.rdata, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_busy3", bus3.busy, 0);
      rst_n = 1;
      step;

      // T1: m0 write
      bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 32'h10;
      bus.m0_rw_type = 3'b010; bus.m0_wdata = 32'hDEADBEEF;
      step;
      chk("t1_gnt0", bus.m0_gnt, 1);
      chk("t1_gnt1", bus.m1_gnt, 0);
      chk("t1_wr_en", bus.mem_wr_en, 1);
      chk("t1_addr", bus.mem_addr, 32'h10);
      chk("t1_rw", 32'(bus.mem_rw_type), 2);
      chk("t1_dat", bus.mem_dat_o, 32'hDEADBEEF);
      chk("t1_busy", bus.busy, 1);
      bus.m0_req = 0;
      step;
      chk("t1_ack0", bus.m0_ack, 1);
      chk("t1_err", bus.err, 0);
      chk("t1_wr_en_off", bus.mem_wr_en, 0);
      chk("t1_gnt0_off", bus.m0_gnt, 0);
      step;
      chk("t1_idle", bus.busy, 0);
      chk("t1_ack0_off", bus.m0_ack, 0);

      // T2: m1 read back
      bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 32'h10;
      bus.m1_rw_type = 3'b010;
      step;
      chk("t2_gnt1", bus.m1_gnt, 1);
      chk("t2_gnt0", bus.m0_gnt, 0);
      chk("t2_wr_en", bus.mem_wr_en, 0);
      bus.m1_req = 0;
      step;
      chk("t2_ack1_early", bus.m1_ack, 0);
      chk("t2_busy", bus.busy, 1);
      step;
      chk("t2_ack1", bus.m1_ack, 1);
      chk("t2_ack0", bus.m0_ack, 0);
      chk("t2_rdata", bus.rdata, 32'hDEADBEEF);
      chk("t2_err", bus.err, 0);
      step;

      // T3: continuous contention, starvation guard
      bus.m0_we = 1; bus.m0_addr = 32'h20;
      bus.m0_rw_type = 3'b010; bus.m0_wdata = 32'h11111111;
      bus.m1_we = 1; bus.m1_addr = 32'h24;
      bus.m1_rw_type = 3'b010; bus.m1_wdata = 32'h22222222;
      bus.m0_req = 1; bus.m1_req = 1;
      g = 0;
      for (int c = 0; c < 60 && g < 10; c++) begin
         step;
         chk("t3_ack_both", 32'(bus.m0_ack & bus.m1_ack), 0);
         if (bus.m0_gnt | bus.m1_gnt) begin
            chk("t3_gnt_both", 32'(bus.m0_gnt & bus.m1_gnt), 0);
            chk("t3_order", 32'(bus.m1_gnt), (g % 5 == 4) ? 1 : 0);
            g++;
         end
      end
      chk("t3_count", g, 10);
      bus.m0_req = 0; bus.m1_req = 0;
      step; step;
      chk("t3_idle", bus.busy, 0);

      // T4: range boundary
      bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h4000;
      bus.m0_rw_type = 3'b010;
      step;
      chk("t4_gnt0", bus.m0_gnt, 1);
      chk("t4_wr_en", bus.mem_wr_en, 0);
      bus.m0_req = 0;
      step;
      chk("t4_ack0", bus.m0_ack, 1);
      chk("t4_err", bus.err, 1);
      chk("t4_rdata", bus.rdata, 0);
      step;
      bus.m0_req = 1; bus.m0_we = 1; bus.m0_wdata = 32'h5555AAAA;
      step;
      chk("t4w_wr_en", bus.mem_wr_en, 0);
      bus.m0_req = 0;
      step;
      chk("t4w_ack0", bus.m0_ack, 1);
      chk("t4w_err", bus.err, 1);
      step;
      bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h3FFC;
      step;
      chk("t4v_gnt0", bus.m0_gnt, 1);
      bus.m0_req = 0;
      step;
      chk("t4v_ack_early", bus.m0_ack, 0);
      step;
      chk("t4v_ack0", bus.m0_ack, 1);
      chk("t4v_err", bus.err, 0);
      chk("t4v_rdata", bus.rdata, 32'hA000003F);
      step;

      // T5: reset during WAIT abandons the read
      bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h24;
      step;
      chk("t5_gnt0", bus.m0_gnt, 1);
      bus.m0_req = 0;
      step;
      rst_n = 0;
      step;
      chk("t5_busy", bus.busy, 0);
      chk("t5_ack0", bus.m0_ack, 0);
      chk("t5_rdata", bus.rdata, 0);
      chk("t5_addr", bus.mem_addr, 0);
      chk("t5_gnt0_off", bus.m0_gnt, 0);
      rst_n = 1;
      step;
      chk("t5_no_ack", bus.m0_ack, 0);
      chk("t5_idle", bus.busy, 0);
      bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 32'h24;
      step;
      chk("t5_gnt1", bus.m1_gnt, 1);
      bus.m1_req = 0;
      step;
      step;
      chk("t5_ack1", bus.m1_ack, 1);
      chk("t5_rdata_new", bus.rdata, 32'h22222222);
      step;

      // T6: RD_LAT=3 read, requests held during RESP
      bus3.m0_req = 1; bus3.m0_we = 0; bus3.m0_addr = 32'h8;
      bus3.m0_rw_type = 3'b010;
      step;
      chk("t6_gnt0", bus3.m0_gnt, 1);
      bus3.m0_req = 0;
      step;
      chk("t6_ack_n2", bus3.m0_ack, 0);
      step;
      chk("t6_ack_n3", bus3.m0_ack, 0);
      step;
      chk("t6_ack_n4", bus3.m0_ack, 0);
      step;
      chk("t6_ack0", bus3.m0_ack, 1);
      chk("t6_rdata", bus3.rdata, 32'hB0000002);
      bus3.m0_req = 1;
      bus3.m1_req = 1; bus3.m1_we = 0; bus3.m1_addr = 32'hC;
      bus3.m1_rw_type = 3'b010;
      step;
      chk("t6_idle_gnt0", bus3.m0_gnt, 0);
      chk("t6_idle_gnt1", bus3.m1_gnt, 0);
      chk("t6_idle_busy", bus3.busy, 0);
      step;
      chk("t6_regnt0", bus3.m0_gnt, 1);
      chk("t6_regnt1", bus3.m1_gnt, 0);
      bus3.m0_req = 0; bus3.m1_req = 0;
      step; step; step; step; step; step;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
